param_dual_port_ram: RTL and testbench
======================================

// Module: param_dual_port_ram
// PURPOSE
//  Parametrised simple dual-port RAM: one write port, one independent read port, shared clock.
//  Successor to the 8x256 single-port RAM in the memory library. Adds:
//   - configurable width/depth; read-during-write policy select; optional output register
//   - a post-reset clear sequencer that zeroes every location; rd_valid qualifying d_out
//  Sits under buffers/FIFOs that need a same-cycle write and read at different addresses.
// PARAMETERS
//  DATA_WIDTH  8  bits per word
//  ADDR_WIDTH  8  address bits; DEPTH = 2**ADDR_WIDTH words
//  RDW_MODE    0  same-address read+write in one cycle: 0 = read-first (old data), 1 = write-first (new data)
//  OUT_REG     0  0 = read latency 1 clk; 1 = extra output register, read latency 2 clk
// PORTS
//  clk       in   1           clock, all logic on posedge
//  rst       in   1           synchronous active-high reset
//  wr        in   1           write strobe, sampled on posedge
//  wr_addr   in   ADDR_WIDTH  write address
//  d_in      in   DATA_WIDTH  write data
//  rd        in   1           read strobe, sampled on posedge
//  rd_addr   in   ADDR_WIDTH  read address
//  d_out     out  DATA_WIDTH  read data, valid when rd_valid=1
//  rd_valid  out  1           d_out qualifier, one pulse per accepted read
//  busy      out  1           1 while the clear sequence runs; wr/rd ignored
//  par_err   out  1           only with PARITY_EN: parity mismatch on the current d_out
// BEHAVIOUR
//  Reset: rst=1 at posedge -> state CLEAR, clr_cnt=0, busy=1, rd_valid=0, d_out=0, par_err=0, pipeline flushed.
//  FSM: CLEAR -> READY.
//   - CLEAR: each cycle writes 0 to mem[clr_cnt], clr_cnt++. After the write of DEPTH-1 -> READY.
//   - Clear takes exactly DEPTH cycles after rst deasserts; busy drops on the cycle READY is entered.
//   - READY stays until the next rst.
//  rst asserted mid-CLEAR or mid-READY: sequence restarts from address 0; in-flight reads are dropped (no rd_valid).
//  CLEAR: wr and rd are ignored (no write, no rd_valid). The user waits for busy=0.
//  Write (READY, wr=1): mem[wr_addr] <= d_in at posedge.
//  Read (READY, rd=1): address captured at edge N.
//   - OUT_REG=0: d_out and rd_valid=1 after edge N+1.
//   - OUT_REG=1: after edge N+2.
//   - Back-to-back reads pipeline fully: one result per clock.
//   - d_out holds its last value when rd_valid=0.
//  Collision (wr & rd, wr_addr==rd_addr, same edge):
//   - RDW_MODE=0 returns the pre-write word; RDW_MODE=1 returns d_in.
//   - Different addresses: no interaction.
//  Address wrap: none internal; addresses are full-range, DEPTH-1 is legal, no out-of-range case.
//  rd_valid is never asserted for a read issued while busy=1, including the final CLEAR cycle.
// CONFIGURATION
//  PARITY_EN defined:
//   - storage is DATA_WIDTH+1 bits; the write stores even parity (^d_in); clear stores parity 0.
//   - par_err = 1 alongside rd_valid when the stored parity != ^(stored data); otherwise 0.
//   - par_err follows the same latency as d_out; reset value 0.
//  PARITY_EN undefined: no par_err port, no parity storage, DATA_WIDTH-bit words only.
// TESTING (defaults DATA_WIDTH=8, ADDR_WIDTH=8, unless stated)
//  1. Release rst -> busy=1 for exactly 256 clocks, then 0; read all 256 addresses -> every d_out=8'h00, 256 rd_valid pulses.
//  2. Write 8'hA5 to 8'h10, read 8'h10 next cycle -> d_out=8'hA5 with rd_valid 1 clk later (OUT_REG=1: 2 clk later).
//  3. Preload 8'h3C at 8'h20; same edge wr 8'hC3 and rd at 8'h20 -> RDW_MODE=0: 8'h3C; RDW_MODE=1: 8'hC3; later read 8'hC3.
//  4. Stream 512 random writes/reads at different addresses every clock vs a scoreboard model -> zero mismatches, no rd_valid gaps.
//  5. rst pulsed at clear count 100, with rd=1 during busy -> clear restarts, busy lasts 256 clocks from release, rd_valid stays 0.
//  6. PARITY_EN: write 8'h01 at 8'h05, force the stored parity bit hierarchically, read 8'h05 -> par_err=1 with rd_valid; unforced word -> par_err=0.

Source files
------------

// File: rtl/param_dual_port_ram_if.sv
// param_dual_port_ram_if: write/read/status bundle for param_dual_port_ram (wr, wr_addr, d_in, rd, rd_addr in; d_out, rd_valid, busy, par_err out; par_err only with PARITY_EN)
interface param_dual_port_ram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                  wr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] d_in;
  logic                  rd;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] d_out;
  logic                  rd_valid;
  logic                  busy;
`ifdef PARITY_EN
  logic                  par_err;
  modport master (output wr, wr_addr, d_in, rd, rd_addr, input d_out, rd_valid, busy, par_err);
  modport slave  (input wr, wr_addr, d_in, rd, rd_addr, output d_out, rd_valid, busy, par_err);
`else
  modport master (output wr, wr_addr, d_in, rd, rd_addr, input d_out, rd_valid, busy);
  modport slave  (input wr, wr_addr, d_in, rd, rd_addr, output d_out, rd_valid, busy);
`endif
endinterface

// File: rtl/param_dual_port_ram.sv
// param_dual_port_ram: simple dual-port RAM with post-reset clear, RDW select, optional out reg, optional parity (PARITY_EN); ports clk, rst, bus (slave: wr/wr_addr/d_in/rd/rd_addr in, d_out/rd_valid/busy/par_err out)
module param_dual_port_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RDW_MODE   = 0,
  parameter int OUT_REG    = 0
) (
  input logic                  clk,
  input logic                  rst,
  param_dual_port_ram_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef PARITY_EN
  localparam int W = DATA_WIDTH + 1;
`else
  localparam int W = DATA_WIDTH;
`endif
  typedef enum logic {CLEAR, READY} state_t;
  state_t                state, state_nx;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [W-1:0]          mem [DEPTH];
  logic [W-1:0]          w_word, r1, r2, r3;
  logic                  v1, v2, v3, rd_ok, wr_ok;
`ifdef PARITY_EN
  assign w_word = {^bus.d_in, bus.d_in};
`else
  assign w_word = bus.d_in;
`endif
  always_ff @(posedge clk)
    if (rst) state <= CLEAR;
    else state <= state_nx;
  always_comb state_nx = (state == CLEAR && &clr_cnt) ? READY : state;
  always_comb begin
    bus.busy = state == CLEAR;
    rd_ok    = state == READY && bus.rd;
    wr_ok    = state == READY && bus.wr;
  end
  always_ff @(posedge clk)
    if (rst) clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
  always_ff @(posedge clk)
    if (!rst) begin
      if (state == CLEAR) mem[clr_cnt] <= '0;
      else if (wr_ok) mem[bus.wr_addr] <= w_word;
    end
  // Stage 1 samples the array with this edge's write still pending, so the
  // array itself gives old data; write-first bypasses d_in on a collision.
  always_ff @(posedge clk)
    if (rst) begin
      v1 <= 1'b0;
      r1 <= '0;
      v2 <= 1'b0;
      r2 <= '0;
    end else begin
      v1 <= rd_ok;
      if (rd_ok) r1 <= (RDW_MODE != 0 && wr_ok && bus.wr_addr == bus.rd_addr) ? w_word : mem[bus.rd_addr];
      v2 <= v1;
      if (v1) r2 <= r1;
    end
  if (OUT_REG != 0) begin : g_oreg
    always_ff @(posedge clk)
      if (rst) begin
        v3 <= 1'b0;
        r3 <= '0;
      end else begin
        v3 <= v2;
        if (v2) r3 <= r2;
      end
  end else begin : g_noreg
    assign v3 = v2;
    assign r3 = r2;
  end
  assign bus.d_out    = r3[DATA_WIDTH-1:0];
  assign bus.rd_valid = v3;
`ifdef PARITY_EN
  assign bus.par_err  = v3 & (r3[DATA_WIDTH] ^ (^r3[DATA_WIDTH-1:0]));
`endif
endmodule

// File: tb/tb_param_dual_port_ram.sv
// tb_param_dual_port_ram: randomized scoreboard bench for param_dual_port_ram
module tb_param_dual_port_ram;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int RDW = 0;
  localparam int OREG = 0;
  localparam int LAT = 1 + OREG;
  typedef struct packed {logic [DW-1:0] d; logic pe;} exp_t;
  logic clk = 0;
  logic rst = 1;
  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  exp_t exp_q[$];
  logic [DW-1:0] model [1<<AW];
  logic pe_next = 0;
  param_dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  param_dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RDW_MODE(RDW), .OUT_REG(OREG)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  always @(negedge clk)
    if (bus.rd_valid) begin
      exp_t e;
      valid_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rd_valid: got d_out=%h with no read pending", bus.d_out);
      end else begin
        e = exp_q.pop_front();
        if (bus.d_out !== e.d) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h", bus.d_out, e.d);
        end
`ifdef PARITY_EN
        checks++;
        if (bus.par_err !== e.pe) begin
          errors++;
          $display("FAIL par_err: got %b expected %b", bus.par_err, e.pe);
        end
`endif
      end
    end
  task automatic step(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                      input logic r, input logic [AW-1:0] ra);
    bus.wr = w; bus.wr_addr = wa; bus.d_in = d; bus.rd = r; bus.rd_addr = ra;
    @(posedge clk);
    if (r) exp_q.push_back({(RDW != 0 && w && wa == ra) ? d : model[ra], pe_next});
    if (w) model[wa] = d;
    #1;
    bus.wr = 0; bus.rd = 0;
  endtask
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
  endtask
  task automatic drain(input string name);
    repeat (LAT + 1) @(negedge clk);
    #1;
    check(name, exp_q.size(), 0);
  endtask
  initial begin
    int n, k;
    logic [AW-1:0] wa, ra;
    bus.wr = 0; bus.rd = 0; bus.wr_addr = 0; bus.rd_addr = 0; bus.d_in = 0;
    foreach (model[i]) model[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(bus.busy), 1);
    check("reset_rd_valid", int'(bus.rd_valid), 0);
    check("reset_d_out", int'(bus.d_out), 0);
    @(posedge clk); #1; rst = 0;
    count_busy(n);
    check("clear_busy_cycles", n, 256);
    @(posedge clk); #1;
    valid_cnt = 0;
    for (int a = 0; a < 256; a++) step(0, 0, 0, 1, AW'(a));
    drain("clear_readback_drain");
    check("clear_readback_pulses", valid_cnt, 256);
    step(1, 8'h10, 8'hA5, 0, 0);
    step(0, 0, 0, 1, 8'h10);
    k = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.rd_valid) break;
      k++;
    end
    check("read_latency", k, LAT);
    check("read_a5", int'(bus.d_out), 8'hA5);
    drain("lat_drain");
    step(1, 8'h20, 8'h3C, 0, 0);
    step(1, 8'h20, 8'hC3, 1, 8'h20);
    step(0, 0, 0, 1, 8'h20);
    drain("collision_drain");
    valid_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      wa = AW'($urandom);
      ra = AW'($urandom);
      if (ra == wa) ra = ra ^ 1;
      step($urandom_range(0, 3) != 0, wa, DW'($urandom), 1, ra);
    end
    drain("stream_no_gap");
    check("stream_pulses", valid_cnt, 512);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    bus.rd = 1; bus.rd_addr = 8'h10;
    valid_cnt = 0;
    repeat (100) @(posedge clk);
    #1; rst = 1;
    @(posedge clk); #1; rst = 0;
    count_busy(n);
    bus.rd = 0;
    check("restart_busy_cycles", n, 256);
    check("busy_rd_valid_pulses", valid_cnt, 0);
    foreach (model[i]) model[i] = '0;
    @(posedge clk); #1;
    step(0, 0, 0, 1, 8'h10);
    step(0, 0, 0, 1, 8'h20);
    step(0, 0, 0, 1, 8'hFF);
    drain("post_restart_drain");
`ifdef PARITY_EN
    step(1, 8'h05, 8'h01, 0, 0);
    dut.mem[5][DW] = 1'b0;
    pe_next = 1;
    step(0, 0, 0, 1, 8'h05);
    pe_next = 0;
    step(0, 0, 0, 1, 8'h10);
    drain("parity_drain");
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
